// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the core's
// control path and a valid/ready memory bus. It enforces natural alignment,
// generates byte enables and lane-shifted store data, and returns
// lane-extracted, sign- or zero-extended load data.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus access with an
// error response after TIMEOUT_CYCLES cycles without mem_ready.
module load_store_unit #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t              r_state;
   logic                r_mem_valid;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [NB-1:0]       r_mem_be;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [LB-1:0]       r_lane;
   logic [1:0]          r_size;
   logic                r_unsigned;

   logic [LB-1:0]       w_lane;
   logic                w_misaligned;
   logic                w_illegal;
   logic [DATA_W-1:0]   w_load_data;

`ifdef LSU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       r_tcnt;
`else
   logic                w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Byte-enable mask: 2^size contiguous bytes starting at the lane.
   function automatic logic [NB-1:0] f_be(input logic [1:0] size, input logic [LB-1:0] lane);
      logic [NB-1:0] m;
      case (size)
         2'd0:    m = NB'(1);
         2'd1:    m = NB'(3);
         2'd2:    m = NB'(15);
         default: m = '1;
      endcase
      return m << lane;
   endfunction

   // Keep the low 8<<size bits and fill the rest with zeros or the sign bit.
   function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] size,
                                                 input logic uns);
      logic [DATA_W-1:0] r;
      int                w;
      w = 8 << int'(size);
      if (w > DATA_W) w = DATA_W;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = (i < w) ? d[i] : (~uns & d[w-1]);
      end
      return r;
   endfunction

   assign w_lane      = req_addr[LB-1:0];
   assign w_illegal   = (req_size == 2'd3) && (DATA_W == 32);
   assign w_load_data = f_extend(mem_rdata >> {r_lane, 3'b000}, r_size, r_unsigned);

   // Natural alignment: the low size bits of the address must be zero.
   always_comb begin
      w_misaligned = 1'b0;
      case (req_size)
         2'd0:    w_misaligned = 1'b0;
         2'd1:    w_misaligned = req_addr[0];
         2'd2:    w_misaligned = |req_addr[1:0];
         default: w_misaligned = |req_addr[2:0];
      endcase
   end

   // Request/bus/response sequencer with all outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_mem_valid <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_lane      <= '0;
         r_size      <= 2'd0;
         r_unsigned  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         r_tcnt      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_lane     <= w_lane;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  if (w_misaligned || w_illegal) begin
                     // Rejected without touching the bus.
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_state     <= S_BUS;
                     r_mem_valid <= 1'b1;
                     r_mem_we    <= req_we;
                     r_mem_addr  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                     r_mem_be    <= f_be(req_size, w_lane);
                     r_mem_wdata <= req_we ? (req_wdata << {w_lane, 3'b000}) : '0;
`ifdef LSU_TIMEOUT_EN
                     r_tcnt      <= '0;
`endif
                  end
               end
            end
            S_BUS: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= r_mem_we ? '0 : w_load_data;
               end
`ifdef LSU_TIMEOUT_EN
               else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
`endif
            end
            S_RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE) && resetn;
   assign mem_valid = r_mem_valid;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit and a 64-bit instance side by side,
// directed accesses, an arithmetic reference model and a per-cycle checker.
module tb_load_store_unit;

   logic clk;
   logic rst_n;

   // Stimulus, index 0 = 32-bit instance, 1 = 64-bit instance
   logic        i_rv[2];
   logic        i_we[2];
   logic [1:0]  i_sz[2];
   logic        i_un[2];
   logic [31:0] i_ad[2];
   logic [63:0] i_wd[2];
   logic        i_mr[2];
   logic [63:0] i_rd[2];

   logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_valid, a_mem_we;
   logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_valid, b_mem_we;
   logic [63:0] b_rsp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_be;

   // Observed outputs, widened
   logic        o_rr[2], o_rv[2], o_re[2], o_mv[2], o_mwe[2];
   logic [63:0] o_rd[2], o_ma[2], o_mbe[2], o_mwd[2];

   // Expected transaction per instance
   bit          e_bus[2], e_rsp[2], e_err[2], e_we[2];
   logic [63:0] e_ma[2], e_be[2], e_wd[2], e_rd[2];

   logic [63:0] cap_ma, cap_be, cap_wd, cap_rd;
   logic        cap_err;
   int          n_checks = 0;
   int          n_errors = 0;

   load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) u32 (
      .clk(clk), .resetn(rst_n),
      .req_valid(i_rv[0]), .req_ready(a_req_ready), .req_we(i_we[0]),
      .req_size(i_sz[0]), .req_unsigned(i_un[0]), .req_addr(i_ad[0]),
      .req_wdata(i_wd[0][31:0]),
      .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
      .mem_valid(a_mem_valid), .mem_ready(i_mr[0]), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
      .mem_rdata(i_rd[0][31:0])
   );

   load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) u64 (
      .clk(clk), .resetn(rst_n),
      .req_valid(i_rv[1]), .req_ready(b_req_ready), .req_we(i_we[1]),
      .req_size(i_sz[1]), .req_unsigned(i_un[1]), .req_addr(i_ad[1]),
      .req_wdata(i_wd[1]),
      .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
      .mem_valid(b_mem_valid), .mem_ready(i_mr[1]), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
      .mem_rdata(i_rd[1])
   );

   always_comb begin
      o_rr[0] = a_req_ready;  o_rr[1] = b_req_ready;
      o_rv[0] = a_rsp_valid;  o_rv[1] = b_rsp_valid;
      o_re[0] = a_rsp_err;    o_re[1] = b_rsp_err;
      o_mv[0] = a_mem_valid;  o_mv[1] = b_mem_valid;
      o_mwe[0] = a_mem_we;    o_mwe[1] = b_mem_we;
      o_rd[0] = {32'b0, a_rsp_rdata};  o_rd[1] = b_rsp_rdata;
      o_ma[0] = {32'b0, a_mem_addr};   o_ma[1] = {32'b0, b_mem_addr};
      o_mbe[0] = {60'b0, a_mem_be};    o_mbe[1] = {56'b0, b_mem_be};
      o_mwd[0] = {32'b0, a_mem_wdata}; o_mwd[1] = b_mem_wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   // Reference model: what the bus and the response must look like for a request.
   function automatic void model(input int dw, input bit we, input int sz, input bit uns,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 input logic [63:0] rd,
                                 output bit err, output logic [63:0] ma, output logic [63:0] be,
                                 output logic [63:0] mwd, output logic [63:0] rdo);
      logic [63:0] dm, lane, nbytes, fm, v;
      dm     = (dw == 64) ? '1 : 64'hFFFF_FFFF;
      lane   = addr % 64'(dw / 8);
      nbytes = 64'd1 << sz;
      err    = ((addr % nbytes) != 0) || (sz == 3 && dw == 32);
      ma     = addr - lane;
      be     = ((64'd1 << nbytes) - 1) << lane;
      mwd    = we ? ((wd << (lane * 8)) & dm) : 64'd0;
      if (we || err) begin
         rdo = 64'd0;
      end else begin
         fm = (nbytes == 8) ? '1 : ((64'd1 << (nbytes * 8)) - 1);
         v  = (rd >> (lane * 8)) & fm;
         if (!uns && (((v >> (nbytes * 8 - 1)) & 64'd1) != 0)) v = v | ~fm;
         rdo = v & dm;
      end
   endfunction

   // Per-cycle checker against the expected transaction.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (o_mv[s]) begin
            if (!e_bus[s]) chk1("mem_valid_unexpected", o_mv[s], 1'b0);
            else begin
               chk("mem_addr", o_ma[s], e_ma[s]);
               chk("mem_be", o_mbe[s], e_be[s]);
               chk1("mem_we", o_mwe[s], e_we[s]);
               chk("mem_wdata", o_mwd[s], e_wd[s]);
            end
         end
         if (o_rv[s]) begin
            if (!e_rsp[s]) chk1("rsp_valid_unexpected", o_rv[s], 1'b0);
            else begin
               chk1("rsp_err", o_re[s], e_err[s]);
               chk("rsp_rdata", o_rd[s], e_rd[s]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input int s, input bit we, input int sz, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd);
      logic [63:0] dm;
      dm = (s == 0) ? 64'hFFFF_FFFF : '1;
      model((s == 0) ? 32 : 64, we, sz, uns, {32'b0, addr}, wd & dm, rd & dm,
            e_err[s], e_ma[s], e_be[s], e_wd[s], e_rd[s]);
      e_we[s]  = we;
      e_rsp[s] = 1'b1;
      e_bus[s] = !e_err[s];
      chk1("req_ready_idle", o_rr[s], 1'b1);
      i_rv[s] = 1'b1; i_we[s] = we; i_sz[s] = 2'(sz); i_un[s] = uns;
      i_ad[s] = addr; i_wd[s] = wd & dm;
   endtask

   // One complete access; mem_ready arrives after dly wait cycles.
   task automatic do_req(input int s, input bit we, input int sz, input bit uns,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input int dly, input bit hold);
      logic [63:0] dm;
      dm = (s == 0) ? 64'hFFFF_FFFF : '1;
      setup(s, we, sz, uns, addr, wd, rd);
      step();
      i_rv[s] = hold;
      if (e_err[s]) begin
         chk1("err_rsp_valid", o_rv[s], 1'b1);
         chk1("err_no_bus", o_mv[s], 1'b0);
         cap_err = o_re[s];
         cap_rd  = o_rd[s];
         step();
         chk1("err_ready_again", o_rr[s], 1'b1);
         chk1("err_rsp_done", o_rv[s], 1'b0);
      end else begin
         cap_ma = o_ma[s]; cap_be = o_mbe[s]; cap_wd = o_mwd[s];
         chk1("bus_mem_valid", o_mv[s], 1'b1);
         for (int k = 0; k < dly; k++) begin
            i_mr[s] = 1'b0;
            i_rd[s] = $urandom() & dm;
            chk1("wait_mem_valid", o_mv[s], 1'b1);
            chk1("wait_not_ready", o_rr[s], 1'b0);
            chk1("wait_no_rsp", o_rv[s], 1'b0);
            step();
         end
         i_mr[s] = 1'b1;
         i_rd[s] = rd & dm;
         chk1("bus_mem_valid_last", o_mv[s], 1'b1);
         step();
         i_mr[s] = 1'b0;
         i_rd[s] = ~rd & dm;
         i_rv[s] = 1'b0;
         e_bus[s] = 1'b0;
         chk1("rsp_valid_timing", o_rv[s], 1'b1);
         chk1("mem_valid_dropped", o_mv[s], 1'b0);
         chk1("resp_not_ready", o_rr[s], 1'b0);
         cap_err = o_re[s];
         cap_rd  = o_rd[s];
         step();
         chk1("ready_again", o_rr[s], 1'b1);
         chk1("rsp_pulse_one", o_rv[s], 1'b0);
         chk("rsp_rdata_hold", o_rd[s], e_rd[s]);
      end
      e_rsp[s] = 1'b0;
      i_rv[s] = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         i_rv[s] = 0; i_we[s] = 0; i_sz[s] = 0; i_un[s] = 0;
         i_ad[s] = 0; i_wd[s] = 0; i_mr[s] = 0; i_rd[s] = 0;
         e_bus[s] = 0; e_rsp[s] = 0; e_err[s] = 0; e_we[s] = 0;
         e_ma[s] = 0; e_be[s] = 0; e_wd[s] = 0; e_rd[s] = 0;
      end
      #3;
      for (int s = 0; s < 2; s++) begin
         chk1("rst_req_ready", o_rr[s], 1'b0);
         chk1("rst_mem_valid", o_mv[s], 1'b0);
         chk1("rst_mem_we", o_mwe[s], 1'b0);
         chk1("rst_rsp_valid", o_rv[s], 1'b0);
         chk1("rst_rsp_err", o_re[s], 1'b0);
         chk("rst_mem_addr", o_ma[s], 64'h0);
         chk("rst_mem_be", o_mbe[s], 64'h0);
         chk("rst_mem_wdata", o_mwd[s], 64'h0);
         chk("rst_rsp_rdata", o_rd[s], 64'h0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk1("post_rst_ready32", o_rr[0], 1'b1);
      chk1("post_rst_ready64", o_rr[1], 1'b1);
      step();

      // 32-bit signed byte load from lane 3
      do_req(0, 0, 0, 0, 32'h103, 64'h0, 64'h8011_2233, 0, 0);
      chk("t1_mem_addr", cap_ma, 64'h100);
      chk("t1_mem_be", cap_be, 64'h8);
      chk("t1_rdata", cap_rd, 64'hFFFF_FF80);
      chk1("t1_err", cap_err, 1'b0);

      // 32-bit half store to lane 2
      do_req(0, 1, 1, 0, 32'h202, 64'h0000_ABCD, 64'h5555_5555, 0, 0);
      chk("t2_mem_be", cap_be, 64'hC);
      chk("t2_mem_wdata", cap_wd, 64'hABCD_0000);
      chk("t2_rdata", cap_rd, 64'h0);

      // Misaligned word, then a request accepted two cycles later
      do_req(0, 0, 2, 0, 32'h101, 64'h0, 64'h0, 0, 0);
      chk1("t3_err", cap_err, 1'b1);
      chk("t3_rdata", cap_rd, 64'h0);
      do_req(0, 0, 1, 1, 32'h102, 64'h0, 64'h8765_4321, 0, 0);
      chk("t3b_rdata", cap_rd, 64'h8765);

      // Five wait states with the next request already pending
      do_req(0, 0, 2, 0, 32'h200, 64'h0, 64'h1234_5678, 5, 1);
      chk("t4_rdata", cap_rd, 64'h1234_5678);

      // Remaining 32-bit corners
      do_req(0, 0, 3, 0, 32'h0, 64'h0, 64'h0, 0, 0);
      chk1("t5_double32_err", cap_err, 1'b1);
      do_req(0, 0, 0, 1, 32'h3, 64'h0, 64'h80AA_BBCC, 1, 0);
      chk("t5_ubyte", cap_rd, 64'h80);
      do_req(0, 1, 0, 0, 32'h1, 64'hEF, 64'h0, 2, 0);
      chk("t5_sb_be", cap_be, 64'h2);
      chk("t5_sb_wd", cap_wd, 64'hEF00);
      do_req(0, 0, 1, 0, 32'h3, 64'h0, 64'h0, 0, 0);
      chk1("t5_half_misal", cap_err, 1'b1);

      // 64-bit instance
      do_req(1, 0, 2, 1, 32'h10C, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 0);
      chk("t6_mem_addr", cap_ma, 64'h108);
      chk("t6_mem_be", cap_be, 64'hF0);
      chk("t6_rdata", cap_rd, 64'h0000_0000_DEAD_BEEF);
      do_req(1, 1, 3, 0, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0);
      chk("t6_sd_be", cap_be, 64'hFF);
      chk("t6_sd_wd", cap_wd, 64'h0123_4567_89AB_CDEF);
      do_req(1, 0, 3, 0, 32'h8, 64'h0, 64'h8000_0000_0000_0001, 0, 0);
      chk("t6_ld", cap_rd, 64'h8000_0000_0000_0001);
      do_req(1, 0, 2, 0, 32'h24, 64'h0, 64'h8000_0000_0000_0000, 3, 0);
      chk("t6_lw_signed", cap_rd, 64'hFFFF_FFFF_8000_0000);
      do_req(1, 0, 3, 0, 32'h14, 64'h0, 64'h0, 0, 0);
      chk1("t6_ld_misal", cap_err, 1'b1);

      // mem_ready never arrives
      setup(0, 0, 2, 0, 32'h40, 64'h0, 64'h0);
      cnt = 0;
`ifdef LSU_TIMEOUT_EN
      e_err[0] = 1'b1;
      e_rd[0]  = 64'h0;
      step();
      i_rv[0] = 1'b0;
      for (int c = 0; c < 50 && o_mv[0]; c++) begin
         cnt++;
         step();
      end
      chk("tmo_mv_cycles", 64'(cnt), 64'd4);
      chk1("tmo_rsp_valid", o_rv[0], 1'b1);
      chk1("tmo_rsp_err", o_re[0], 1'b1);
      chk("tmo_rdata", o_rd[0], 64'h0);
      e_bus[0] = 1'b0;
      step();
      chk1("tmo_ready_again", o_rr[0], 1'b1);
      e_rsp[0] = 1'b0;
`else
      step();
      i_rv[0] = 1'b0;
      for (int c = 0; c < 120; c++) begin
         if (o_mv[0]) cnt++;
         step();
      end
      chk("stall_mv_cycles", 64'(cnt), 64'd120);
      #1 rst_n = 1'b0;
      #1;
      chk1("stall_rst_mv", o_mv[0], 1'b0);
      e_bus[0] = 1'b0;
      e_rsp[0] = 1'b0;
      step();
      rst_n = 1'b1;
      step();
`endif

      // Reset pulsed while the 64-bit instance waits on the bus
      setup(1, 0, 2, 0, 32'h118, 64'h0, 64'h0);
      step();
      i_rv[1] = 1'b0;
      step();
      chk1("mid_bus_mv", o_mv[1], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("rst_mid_mv", o_mv[1], 1'b0);
      chk1("rst_mid_rv", o_rv[1], 1'b0);
      chk1("rst_mid_rr", o_rr[1], 1'b0);
      e_bus[1] = 1'b0;
      e_rsp[1] = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         i_mr[1] = 1'b1;
         step();
      end
      i_mr[1] = 1'b0;
      chk1("rst_mid_idle", o_rr[1], 1'b1);
      chk1("rst_mid_no_rsp", o_rv[1], 1'b0);
      do_req(1, 0, 1, 0, 32'h11E, 64'h0, 64'h9ABC_0000_0000_0000, 0, 0);
      chk("rst_recover", cap_rd, 64'hFFFF_FFFF_FFFF_9ABC);

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
